// File: rtl/d_write_buffer_pkg.sv
// ---------------------------------------------------------------------------
// d_write_buffer_pkg
// Shared definitions for the posted-write buffer that sits between d_cache
// and main memory: default geometry, memory-side FSM state encodings and the
// {addr, data} entry layout stored in the write FIFO.
// ---------------------------------------------------------------------------
package d_write_buffer_pkg;

  localparam int DEFAULT_DEPTH = 4;
  localparam int DEFAULT_AW    = 2;

  typedef enum logic [1:0] {
    M_IDLE  = 2'd0,
    M_WRITE = 2'd1,
    M_READ  = 2'd2
  } m_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wb_entry_t;

endpackage

// File: rtl/d_write_buffer_wb_fifo.sv
// ---------------------------------------------------------------------------
// wb_fifo
// Synchronous DEPTH x 64-bit FIFO holding buffered {addr, data} writes.
// Ports:
//   clk, rst   - clock and synchronous active-high reset
//   push       - enqueue push_entry at the rising edge (ignored when full)
//   push_entry - {addr, data} entry to enqueue
//   pop        - drop the head entry at the rising edge (ignored when empty)
//   head       - oldest entry, valid whenever empty is low
//   full/empty - derived from the registered occupancy count
//   count      - number of entries held, 0..DEPTH
// ---------------------------------------------------------------------------
module wb_fifo
  import d_write_buffer_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = DEFAULT_AW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  wb_entry_t       push_entry,
  input  logic            pop,
  output wb_entry_t       head,
  output logic            full,
  output logic            empty,
  output logic [AW:0]     count
);

  wb_entry_t         mem [DEPTH];
  logic [AW-1:0]     head_ptr;
  logic [AW-1:0]     tail_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[head_ptr];

  // Pointer and occupancy bookkeeping. The AW-bit pointers wrap on their own,
  // so a simultaneous push and pop just advances both and leaves count alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (do_push) tail_ptr <= tail_ptr + 1'b1;
      if (do_pop)  head_ptr <= head_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset: a slot is only ever read after a push has
  // filled it, and reset clears the occupancy count.
  always_ff @(posedge clk) begin
    if (do_push) mem[tail_ptr] <= push_entry;
  end

endmodule

// File: rtl/d_write_buffer.sv
// ---------------------------------------------------------------------------
// d_write_buffer
// Posted-write buffer between d_cache's memory port and main memory. Stores
// are absorbed with zero wait states while space remains and drained to
// memory in FIFO order; reads go to memory only once the buffer is fully
// drained, so memory ordering is preserved (no forwarding, no merging).
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   c_a, c_din, c_dout       - cache-side address, write data, read data
//   c_strobe, c_rw, c_ready  - cache request valid, direction (1=write), done
//   m_a, m_din, m_dout       - memory address, write data, read data
//   m_strobe, m_rw, m_ready  - memory request valid, direction (1=write), done
//   wb_empty                 - nothing buffered and no write in flight
// ---------------------------------------------------------------------------
module d_write_buffer
  import d_write_buffer_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = DEFAULT_AW
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] c_a,
  input  logic [31:0] c_din,
  output logic [31:0] c_dout,
  input  logic        c_strobe,
  input  logic        c_rw,
  output logic        c_ready,
  output logic [31:0] m_a,
  output logic [31:0] m_din,
  input  logic [31:0] m_dout,
  output logic        m_strobe,
  output logic        m_rw,
  input  logic        m_ready,
  output logic        wb_empty
);

  m_state_e      state;
  m_state_e      next_state;
  wb_entry_t     head;
  wb_entry_t     push_entry;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          push;
  logic          pop;

  assign push_entry = '{addr: c_a, data: c_din};
  assign wb_empty   = (count == '0) && (state != M_WRITE);

  wb_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .full       (full),
    .empty      (empty),
    .count      (count)
  );

  // Memory-side state register.
  always_ff @(posedge clk) begin
    if (rst) state <= M_IDLE;
    else     state <= next_state;
  end

  // Next-state and output muxing. A write being accepted this cycle counts
  // as pending work in M_IDLE, so the memory write can start the very next
  // cycle. Pending writes always win over a waiting read; reads block new
  // writes until memory answers. Nothing is accepted while rst is high.
  always_comb begin
    next_state = state;
    push       = 1'b0;
    pop        = 1'b0;
    c_ready    = 1'b0;
    c_dout     = '0;
    m_a        = '0;
    m_din      = '0;
    m_strobe   = 1'b0;
    m_rw       = 1'b0;

    case (state)
      M_IDLE: begin
        push    = c_strobe & c_rw & ~full;
        c_ready = push;
        if (!empty || push)          next_state = M_WRITE;
        else if (c_strobe && !c_rw)  next_state = M_READ;
      end

      M_WRITE: begin
        push     = c_strobe & c_rw & ~full;
        c_ready  = push;
        m_strobe = 1'b1;
        m_rw     = 1'b1;
        m_a      = head.addr;
        m_din    = head.data;
        if (m_ready) begin
          pop = 1'b1;
          if (count <= (AW+1)'(1)) next_state = M_IDLE;
        end
      end

      M_READ: begin
        m_strobe = 1'b1;
        m_a      = c_a;
        c_dout   = m_dout;
        c_ready  = m_ready;
        if (m_ready) next_state = M_IDLE;
      end

      default: next_state = M_IDLE;
    endcase

    if (rst) begin
      push    = 1'b0;
      pop     = 1'b0;
      c_ready = 1'b0;
    end
  end

endmodule

// File: doc/d_write_buffer.md
Name: d_write_buffer

Overview:
- Posted-write buffer sitting directly downstream of d_cache, between the cache's memory-side port and main memory.
- Absorbs write-through stores from the cache with zero wait states when not full, and drains them to memory in FIFO order.
- Reads are passed through to memory only after the buffer has fully drained, which preserves memory ordering; there is no forwarding.

Parameters:
- DEPTH, 4, number of buffered write entries (power of 2, >=2).
- AW, 2, log2(DEPTH); pointer width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- c_a  in  32  cache-side address (driven from the cache's m_a).
- c_din  in  32  cache-side write data (driven from the cache's m_din).
- c_dout  out  32  read data returned to the cache (to its m_dout).
- c_strobe  in  1  cache request valid.
- c_rw  in  1  1 = write, 0 = read.
- c_ready  out  1  request consumed or completed this cycle (to the cache's m_ready).
- m_a  out  32  memory address.
- m_din  out  32  memory write data.
- m_dout  in  32  memory read data.
- m_strobe  out  1  memory request valid.
- m_rw  out  1  memory direction, 1 = write.
- m_ready  in  1  memory completes the current request this cycle.
- wb_empty  out  1  buffer holds no entries and no write is in flight.

Behaviour:
- Reset (rst=1 at the clock edge):
  - count, head and tail pointers, and state are cleared; state = M_IDLE.
  - All buffered writes are discarded. This applies mid-drain too: m_strobe is 0 from the next cycle.
  - While in reset and in M_IDLE: m_a=0, m_din=0, m_strobe=0, m_rw=0, c_dout=0, c_ready=0, wb_empty=1.
- Transaction rule: a request is consumed in any cycle where c_strobe & c_ready. The requester must drop or change the request on the following cycle.
- Write accept:
  - c_ready = c_strobe & c_rw & !full (combinational).
  - The entry {c_a, c_din} is enqueued at that clock edge.
  - full and empty are derived from the registered count.
  - When full, a write is refused even if a dequeue happens in the same cycle; it is accepted on the next cycle.
- Memory-side FSM:
  - M_IDLE: if !empty, go to M_WRITE. Else if c_strobe & !c_rw, go to M_READ. Writes always have priority over reads. m_ready is ignored in this state.
  - M_WRITE:
    - Outputs: m_strobe=1, m_rw=1, m_a = head addr, m_din = head data.
    - On m_ready: pop the head. If count>1, stay in M_WRITE and present the next head with no bubble; otherwise go to M_IDLE.
  - M_READ:
    - Outputs: m_strobe=1, m_rw=0, m_a = c_a (combinational).
    - c_dout = m_dout, c_ready = m_ready (same cycle).
    - On m_ready, go to M_IDLE.
    - Write requests are not accepted while in M_READ.
- Latency:
  - Write: 0 wait states when not full. The memory write starts at the earliest the cycle after enqueue.
  - Read: 1 cycle to enter M_READ after the buffer is empty, plus memory latency.
  - After the last drain completes there is one M_IDLE bubble before the read is issued.
- Simultaneous enqueue and dequeue when not full: count is unchanged, and both pointers advance modulo DEPTH (wrap-around).
- Pointer arithmetic: AW-bit pointers wrap naturally; count is AW+1 bits wide, range 0..DEPTH.
- wb_empty = (count==0) & (state != M_WRITE).
- No address merging and no forwarding: two writes to the same address both go to memory, in order.

Decomposition:
- Shared header holds the state encodings (M_IDLE=2'd0, M_WRITE=2'd1, M_READ=2'd2) and the default DEPTH/AW.
- One sub-module, wb_fifo: a synchronous DEPTH x 64-bit {addr, data} FIFO.
  - Inputs: push, pop.
  - Outputs: head data, full, empty, count.
- d_write_buffer contains the FSM and the output muxing.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with c_strobe=1 -> c_ready=0, m_strobe=0, m_a=0, wb_empty=1.
2. Single write c_a=0x104, c_din=0x5555aaaa, m_ready=0:
   - c_ready=1 in the strobe cycle.
   - Next cycle: m_strobe=1, m_rw=1, m_a=0x104, m_din=0x5555aaaa.
   - Pulse m_ready -> m_strobe=0 and wb_empty=1 the following cycle.
3. Fill with m_ready=0: writes to 0x100, 0x104, 0x108, 0x10C are accepted; the 5th write (0x110) sees c_ready=0. Then pulse m_ready each cycle:
   - The 0x110 write is accepted one cycle after the first pop.
   - Memory sees 0x100, 0x104, 0x108, 0x10C, 0x110 in order with no bubbles.
4. Write 0x200 = 0x12345678, then read 0x200:
   - The read's m_rw=0 strobe is not asserted until the write's m_ready and one M_IDLE cycle have passed.
   - Then memory returns m_dout=0xffffffff with m_ready=1 -> c_dout=0xffffffff and c_ready=1 in that same cycle.
5. Read 0x100 with the buffer empty, m_ready after 3 cycles -> m_strobe=1, m_rw=0, m_a=0x100 from the cycle after the strobe; c_ready high for exactly one cycle.
6. Three writes buffered, m_ready=0, rst=1 for one cycle -> next cycle m_strobe=0 and wb_empty=1; no further memory writes occur after reset releases.
